// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches from a combinational memory
// into a small skid FIFO for decode. Optional range trap enabled by IF_FETCH_TRAP_EN.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned MEM_SIZE   = 1024,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fetch_busy
`ifdef IF_FETCH_TRAP_EN
  , output logic      fetch_fault
`endif
);

  localparam int unsigned PW = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN
`ifdef IF_FETCH_TRAP_EN
    , FAULT
`endif
  } state_t;

  state_t          state, state_nxt;
  logic [31:0]     pc;
  logic [31:0]     target;
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic [31:0]     instr_q [FIFO_DEPTH];
  logic [31:0]     pc_q    [FIFO_DEPTH];
  logic            enq, deq;
  logic            pc_ok;
  logic            unused_bits;

  assign target = {redirect_pc[31:2], 2'b00};

`ifdef IF_FETCH_TRAP_EN
  localparam logic [32:0] LIMIT = 33'(MEM_SIZE) * 33'd4;
  logic target_ok;
  assign pc_ok       = ({1'b0, pc} < LIMIT);
  assign target_ok   = ({1'b0, target} < LIMIT);
  assign fetch_fault = (state == FAULT);
  assign unused_bits = ^redirect_pc[1:0];
`else
  assign pc_ok       = 1'b1;
  assign unused_bits = ^{redirect_pc[1:0], MEM_SIZE};
`endif

  assign mem_addr   = pc;
  assign if_valid   = (count != '0);
  assign if_instr   = instr_q[head];
  assign if_pc      = pc_q[head];
  assign fetch_busy = (state == RUN);

  // Redirect suppresses both FIFO ports so the flush wins over a same-cycle handshake.
  always_comb begin
    state_nxt = state;
    deq       = 1'b0;
    enq       = 1'b0;
    if (!redirect) begin
      deq = if_valid && if_ready;
      enq = (state == RUN) && pc_ok && ((count < CW'(FIFO_DEPTH)) || deq);
    end
    case (state)
      IDLE: if (!redirect && fetch_en) state_nxt = RUN;
      RUN: begin
        if (!fetch_en) state_nxt = IDLE;
`ifdef IF_FETCH_TRAP_EN
        if (!redirect && !pc_ok) state_nxt = FAULT;
`endif
      end
`ifdef IF_FETCH_TRAP_EN
      FAULT: if (redirect && target_ok) state_nxt = fetch_en ? RUN : IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      state <= state_nxt;
      if (redirect) begin
        pc    <= target;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (enq) begin
          instr_q[tail] <= mem_rdata;
          pc_q[tail]    <= pc;
          tail          <= tail + 1'b1;
          pc            <= pc + 32'd4;
        end
        if (deq) head <= head + 1'b1;
        if (enq && !deq)      count <= count + 1'b1;
        else if (deq && !enq) count <= count - 1'b1;
      end
    end
  end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Instruction-fetch sequencer for the single-ported, combinational instruction memory in the MIPS core. It owns the program counter and drives the memory byte address. It captures each returned 32-bit word with its PC into a 2-entry skid FIFO and presents it to decode over a valid/ready handshake. Branch/jump redirects from later stages flush queued instructions and restart fetch at the target.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
MEM_SIZE, 1024, instruction memory depth in 32-bit words; used only by the optional trap.
FIFO_DEPTH, 2, fetch-buffer entries; legal values are 2 and 4.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
fetch_en  input  1  permits fetching; sampled every cycle.
mem_addr  output  32  byte address to instruction memory; always equals the current PC.
mem_rdata  input  32  instruction word returned combinationally for mem_addr.
redirect  input  1  branch/jump taken; one-cycle pulse.
redirect_pc  input  32  target byte address; bits [1:0] are ignored and forced to 0.
if_valid  output  1  FIFO head is valid.
if_ready  input  1  decode accepts the head.
if_instr  output  32  head instruction.
if_pc  output  32  byte address of the head instruction.
fetch_busy  output  1  high in the RUN state.

Behaviour:
- Reset values (asynchronous): PC = RESET_PC, FIFO empty, if_valid = 0, if_instr = 0, if_pc = 0, state = IDLE, fetch_busy = 0, and fetch_fault = 0 if that port is present.
- State machine:
  - IDLE: no enqueue. Moves to RUN on the cycle after fetch_en = 1 is sampled.
  - RUN: fetches. Returns to IDLE when fetch_en = 0 is sampled. Queued entries are kept and remain drainable from IDLE.
  - FAULT: exists only with the optional feature.
- Dequeue: when if_valid && if_ready at a clock edge, the head pops. if_instr and if_pc are driven from the FIFO registers, never combinationally from mem_rdata.
- Enqueue in RUN: occurs when count < FIFO_DEPTH, or when count == FIFO_DEPTH and a dequeue happens in the same cycle. On enqueue, {mem_rdata, PC} is written at the tail and PC <= PC + 4.
- Fetch latency: 1 cycle. A word addressed in cycle N is visible on if_instr in cycle N+1.
- Full FIFO with no dequeue: PC holds and mem_addr is stable; no word is lost or duplicated.
- Same-cycle enqueue and dequeue: count is unchanged. This is legal at both empty-with-pending and full.
- Redirect (any state): FIFO flushes and count becomes 0. PC <= {redirect_pc[31:2], 2'b00}. No enqueue and no dequeue happen that cycle, even if if_ready = 1; redirect has priority over everything except reset. if_valid = 0 on the next cycle; the target instruction appears the cycle after that if in RUN.
- Redirect while in IDLE: loads PC only; the state stays IDLE.
- PC wrap: arithmetic is modulo 2^32, so 32'hFFFF_FFFC + 4 gives 0.
- Reset mid-operation: everything returns immediately to reset values and in-flight entries are discarded.
- fetch_busy = (state == RUN).

Optional Feature:
Macro: IF_FETCH_TRAP_EN.
- Defined:
  - Adds output port fetch_fault (1 bit) and state FAULT.
  - In RUN, if PC >= MEM_SIZE*4, the word is not enqueued. The FSM enters FAULT on the next edge, and fetch_fault goes high and stays high.
  - In FAULT, enqueue is blocked but the FIFO still drains.
  - A redirect to an in-range address clears fetch_fault and enters RUN if fetch_en = 1, otherwise IDLE. A redirect to an out-of-range address keeps FAULT.
- Undefined: there is no port and no FAULT state. Out-of-range PCs are fetched normally; the memory index truncates and the fetch wraps.

Test Plan:
- Reset, fetch_en = 1, if_ready = 1, memory word k = 32'h1000_0000+k -> first if_valid two cycles after fetch_en; then one instruction per cycle with if_pc = 0, 4, 8 and if_instr = 32'h1000_0000, 32'h1000_0001, 32'h1000_0002.
- if_ready = 0 for 5 cycles while running -> exactly 2 entries held (PC 0, 4); mem_addr frozen at 8; after release, entries 0, 4, 8 arrive in order with no gap or duplicate.
- Redirect with redirect_pc = 32'h0000_0103 while FIFO full and if_ready = 1 -> nothing is accepted that cycle; if_valid = 0 the next cycle; then if_pc = 32'h100.
- fetch_en dropped with 2 entries queued -> fetch_busy = 0; both entries drain; mem_addr stays constant.
- PC = 32'hFFFF_FFFC in RUN -> next if_pc = 0 (macro undefined).
- IF_FETCH_TRAP_EN, MEM_SIZE = 16, run from 0 -> last enqueued PC is 32'h3C; fetch_fault rises; redirect to 0 clears it and fetching resumes.
